// File: rtl/fetch_unit.sv
// fetch_unit: MIPS program counter and fetch stage with valid/ready handoff to decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter int          MEM_BYTES = 64,
    parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [5:0]  imem_addr,
    input  logic [31:0] imem_rd,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic        halted,
    output logic [15:0] fetch_count
);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] seqPc;
    logic [31:0] branchPc;
    logic [31:0] jumpPc;
    logic [31:0] nextPc;

    // Redirects are relative to the instruction being accepted, not the live pc
    assign seqPc     = pc_out + 32'd4;
    assign branchPc  = seqPc + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign jumpPc    = {seqPc[31:28], jump_target, 2'b00};
    assign nextPc    = jump ? jumpPc : branch_taken ? branchPc : seqPc;
    assign imem_addr = pc[5:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) state <= FETCH;
                FETCH: begin
                    if (pc >= MEM_LIMIT) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        instr       <= imem_rd;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        state       <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (instr_ready) begin
                        fetch_count <= fetch_count + 16'(fetch_count != 16'hFFFF);
                        instr_valid <= 1'b0;
                        if (instr == HALT_WORD) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            pc    <= nextPc;
                            state <= FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
